// File: rtl/norm_pkg.sv
// Shared widths, rounding-mode codes and result layout for the norm_round stage.
// norm_res_t describes the default configuration; the modules build the same layout at their own widths.
package norm_pkg;

    localparam logic [1:0] RNE = 2'd0;
    localparam logic [1:0] RTZ = 2'd1;

    function automatic int exp_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    function automatic int sh_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    function automatic int res_w(input int data_w, input int mant_w);
        return 2 + exp_w(data_w) + mant_w;
    endfunction

    localparam int NR_DATA_W = 8;
    localparam int NR_MANT_W = 4;
    localparam int NR_EXP_W  = exp_w(NR_DATA_W);

    typedef struct packed {
        logic                 zero;
        logic                 inexact;
        logic [NR_EXP_W-1:0]  exp;
        logic [NR_MANT_W-1:0] mant;
    } norm_res_t;

endpackage

// File: rtl/norm_round_core.sv
// Combinational round-to-nearest-even and exponent recovery for one normalized vector.
// Output is packed {zero, inexact, exp, mant}, identical in layout to norm_res_t.
module norm_round_core
    import norm_pkg::*;
#(
    parameter int          DATA_W   = NR_DATA_W,
    parameter int          MANT_W   = NR_MANT_W,
    parameter logic [1:0]  RND_MODE = RNE,
    localparam int         SH_W     = sh_w(DATA_W),
    localparam int         EXP_W    = exp_w(DATA_W),
    localparam int         RES_W    = res_w(DATA_W, MANT_W)
) (
    input  logic [DATA_W-1:0] vec,
    input  logic [SH_W-1:0]   shift,
    output logic [RES_W-1:0]  res
);

    typedef struct packed {
        logic              zero;
        logic              inexact;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } res_t;

    res_t              r;
    logic [MANT_W-1:0] kept;
    logic              guard;
    logic              sticky;
    logic              up;
    logic [EXP_W-1:0]  exp_pre;

    assign kept    = vec[DATA_W-1 -: MANT_W];
    assign guard   = vec[DATA_W-1-MANT_W];
    assign sticky  = |vec[DATA_W-2-MANT_W:0];
    assign up      = (RND_MODE == RNE) && guard && (sticky || kept[0]);
    assign exp_pre = EXP_W'(DATA_W - 1) - shift;

    always_comb begin
        r = '0;
        if (vec == '0) begin
            r.zero = 1'b1;
        end else begin
            r.inexact = guard || sticky;
            // Rounding an all-ones mantissa carries out: renormalize to 1.00..0 and bump the exponent.
            if (up && (&kept)) begin
                r.mant = {1'b1, {(MANT_W-1){1'b0}}};
                r.exp  = exp_pre + EXP_W'(1);
            end else begin
                r.mant = kept + MANT_W'(up);
                r.exp  = exp_pre;
            end
        end
    end

    assign res = r;

endmodule

// File: rtl/norm_round.sv
// Two-stage registered rounding/packing stage behind the leading-zero normalizer.
// S1 holds the raw vector/shift, S2 holds the rounded result; handshake has no skid buffer.
module norm_round
    import norm_pkg::*;
#(
    parameter int  DATA_W = NR_DATA_W,
    parameter int  MANT_W = NR_MANT_W,
    localparam int SH_W   = sh_w(DATA_W),
    localparam int EXP_W  = exp_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_vec,
    input  logic [SH_W-1:0]   in_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_inexact
);

    localparam int STAGES = 2;
    localparam int RES_W  = res_w(DATA_W, MANT_W);

    typedef struct packed {
        logic              zero;
        logic              inexact;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } res_t;

    logic [STAGES:1]   vld_pipe;
    logic [DATA_W-1:0] s1_vec;
    logic [SH_W-1:0]   s1_shift;
    logic [RES_W-1:0]  core_res;
    res_t              out_q;
    logic              out_free;

    // S2 can take a new result when empty or when its current result leaves this cycle.
    assign out_free = !vld_pipe[2] || out_ready;
    assign in_ready = !vld_pipe[1] || out_free;

    norm_round_core #(
        .DATA_W   (DATA_W),
        .MANT_W   (MANT_W),
        .RND_MODE (RNE)
    ) u_core (
        .vec   (s1_vec),
        .shift (s1_shift),
        .res   (core_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_vec   <= '0;
            s1_shift <= '0;
            out_q    <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_vec   <= in_vec;
                    s1_shift <= in_shift;
                end
            end
            if (out_free) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1])
                    out_q <= core_res;
            end
        end
    end

    assign out_valid   = vld_pipe[2];
    assign out_mant    = out_q.mant;
    assign out_exp     = out_q.exp;
    assign out_zero    = out_q.zero;
    assign out_inexact = out_q.inexact;

endmodule

// File: tb/tb_norm_round.sv
// Scoreboard bench for norm_round (DATA_W=8, MANT_W=4): directed rounding cases, random stream, reset mid-flight.
module tb_norm_round;

    localparam int DW = 8;
    localparam int MW = 4;
    localparam int SW = 4;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_vec = '0;
    logic [SW-1:0] in_shift = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_inexact;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [9:0] sb_q[$];
    int         acc_q[$];
    bit         lat_chk = 0;
    bit         tput_en = 0;
    bit         have_prev = 0;
    int         prev_cyc = 0;
    bit         prev_stall = 0;
    logic [9:0] prev_out = '0;

    norm_round #(.DATA_W(DW), .MANT_W(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .in_shift    (in_shift),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_mant    (out_mant),
        .out_exp     (out_exp),
        .out_zero    (out_zero),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: {zero, inexact, exp, mant} derived from remainder-vs-half arithmetic.
    function automatic logic [9:0] model(input logic [7:0] v, input logic [3:0] sh);
        int kept, rem, e, m;
        bit up;
        if (v == 0) return 10'b10_0000_0000;
        kept = int'(v) >> 4;
        rem  = int'(v) & 15;
        e    = 7 - int'(sh);
        up   = (rem > 8) || (rem == 8 && (kept % 2) == 1);
        m    = kept + (up ? 1 : 0);
        if (m == 16) begin
            m = 8;
            e = e + 1;
        end
        return {1'b0, rem != 0, 4'(e), 4'(m)};
    endfunction

    always @(negedge clk) begin
        logic [9:0] cur, exp_r;
        int a;
        cur = {out_zero, out_inexact, out_exp, out_mant};
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_hold", 32'(cur), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    exp_r = sb_q.pop_front();
                    a = acc_q.pop_front();
                    chk("mant", 32'(out_mant), 32'(exp_r[3:0]));
                    chk("exp", 32'(out_exp), 32'(exp_r[7:4]));
                    chk("inexact", 32'(out_inexact), 32'(exp_r[8]));
                    chk("zero", 32'(out_zero), 32'(exp_r[9]));
                    if (lat_chk) begin
                        chk("latency", 32'(cyc - a), 2);
                        lat_chk = 0;
                    end
                    if (tput_en && have_prev) chk("tput", 32'(cyc - prev_cyc), 1);
                    prev_cyc = cyc;
                    have_prev = 1;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_vec, in_shift));
                acc_q.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
        end
    end

    task automatic send(input logic [7:0] v, input logic [3:0] sh);
        int t = 0;
        assert (v == 0 || (v[7] && sh <= 4'd7)) else $error("malformed stimulus %0h/%0d", v, sh);
        in_vec = v;
        in_shift = sh;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb_q.size()), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_outs", 32'({out_zero, out_inexact, out_exp, out_mant}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_idle_valid", 32'(out_valid), 0);

        // Directed rounding cases, back-to-back with the consumer always ready.
        out_ready = 1'b1;
        lat_chk = 1;
        tput_en = 1;
        have_prev = 0;
        send(8'b1011_1000, 4'd2);
        send(8'b1010_1000, 4'd0);
        send(8'b1010_1001, 4'd0);
        send(8'b1111_1000, 4'd0);
        send(8'b1001_0000, 4'd3);
        send(8'h00, 4'd7);
        send(8'b1111_1111, 4'd7);
        wait_drain();
        tput_en = 0;

        // Random stream with random backpressure and a forced 5-cycle stall.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [7:0] v;
                    v = ($urandom % 6 == 0) ? 8'h00 : (8'h80 | 8'($urandom));
                    send(v, 4'($urandom % 8));
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (j >= 4 && j < 9) ? 1'b0 : 1'($urandom % 2);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset with two beats in flight.
        send(8'b1100_0110, 4'd1);
        send(8'b1000_0001, 4'd5);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_outs", 32'({out_zero, out_inexact, out_exp, out_mant}), 0);
        sb_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
